// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: front end for the 0-999 s counter / BCD display.
// Conditions the raw active-low start/stop and clear keys (2-FF sync,
// debounce, press-edge detect), sequences IDLE/RUN/PAUSE and produces the
// one-cycle 1 s count-enable tick plus the one-cycle clear pulse.
// Build option STEP_KEY_EN: adds a single-step key that emits one tick
// while stopped (IDLE or PAUSE).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | stopped and cleared, prescaler held at 0
// RUN    | prescaler counting, tick every COUNT_1S cycles
// PAUSE  | stopped, prescaler frozen so the partial second survives
module stopwatch_ctrl #(
  parameter int COUNT_1S        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PW              = 26,
  parameter int DW              = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_start_n_i,
  input  logic       key_clear_n_i,
  input  logic       key_step_n_i,
  output logic       tick_o,
  output logic       clear_o,
  output logic [1:0] state_o,
  output logic       running_o
);

`ifdef STEP_KEY_EN
  localparam int NK     = 3;
  localparam int K_STEP = 2;
`else
  localparam int NK     = 2;
`endif
  localparam int K_START = 0;
  localparam int K_CLEAR = 1;

  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_1S - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic [NK-1:0] keys_n;
`ifdef STEP_KEY_EN
  assign keys_n = {key_step_n_i, key_clear_n_i, key_start_n_i};
`else
  logic unused_step;
  assign unused_step = key_step_n_i;
  assign keys_n      = {key_clear_n_i, key_start_n_i};
`endif

  logic [NK-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, evt_q;
  logic [DW-1:0] cnt_q [NK];
  logic [DW-1:0] cnt_d [NK];

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d, clear_q, clear_d, running_q, running_d;
  logic          start_evt, clr_evt;

  assign start_evt = evt_q[K_START];
  assign clr_evt   = evt_q[K_CLEAR];

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DEB_MAX) deb_d[k] = sync2_q[k];
        else                     cnt_d[k] = cnt_q[k] + DW'(1);
      end
    end
  end

  // Key conditioning registers; reset to released so reset exit makes no press
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      deb_q     <= '1;
      deb_dly_q <= '1;
      evt_q     <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q   <= keys_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      evt_q     <= deb_dly_q & ~deb_q;
      for (int k = 0; k < NK; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: clear beats start when both arrive together
  always_comb begin
    state_d = state_q;
    if (clr_evt) begin
      state_d = S_IDLE;
    end else if (start_evt) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs, evaluated on the pre-edge state so a wrap on the leaving edge still ticks
  always_comb begin
    tick_d    = (state_q == S_RUN) && (pre_q == PRE_MAX);
`ifdef STEP_KEY_EN
    if (evt_q[K_STEP] && (state_q != S_RUN) && !clr_evt) tick_d = 1'b1;
`endif
    clear_d   = clr_evt;
    running_d = (state_d == S_RUN);
  end

  // Prescaler next value: count in RUN, freeze in PAUSE, zero in IDLE or on clear
  always_comb begin
    pre_d = pre_q;
    if (clr_evt) begin
      pre_d = '0;
    end else begin
      case (state_q)
        S_RUN:   pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
        S_PAUSE: pre_d = pre_q;
        default: pre_d = '0;
      endcase
    end
  end

  // Prescaler and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      clear_q   <= clear_d;
      running_q <= running_d;
    end
  end

  assign tick_o    = tick_q;
  assign clear_o   = clear_q;
  assign state_o   = state_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with COUNT_1S=10, DEBOUNCE_CYCLES=4.
// Key presses come from a vector table; the expected tick and clear cycles
// are queued when each press is driven and checked by negedge monitors.
module tb_stopwatch_ctrl;
  localparam int CNT = 10;
  localparam int DB  = 4;
  localparam int LAT = DB + 4;  // drive -> FSM reaction edge (2 sync + DB + evt + fsm)

  logic       clk = 1'b0, rst = 1'b1;
  logic       ks = 1'b1, kc = 1'b1, kp = 1'b1;
  logic       tick, clear, running;
  logic [1:0] state;

  stopwatch_ctrl #(.COUNT_1S(CNT), .DEBOUNCE_CYCLES(DB), .PW(4), .DW(2)) dut (
    .clk_i(clk), .rst_i(rst), .key_start_n_i(ks), .key_clear_n_i(kc),
    .key_step_n_i(kp), .tick_o(tick), .clear_o(clear), .state_o(state),
    .running_o(running));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  int tick_q[$];
  int clr_q[$];
  bit mon_en = 1'b0;

  // expected-behaviour model state
  int m_state = 0, r_start = 0, r_p0 = 0, m_held = 0;

  typedef struct {
    bit s; bit c; bit p;
    int hold; int align; int gap;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tick === 1'b1) begin
        int e;
        e = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
        chk("tick cycle", cyc, e);
      end else if (tick_q.size() > 0 && tick_q[0] <= cyc) begin
        void'(tick_q.pop_front());
        chk("tick expected", tick, 1'b1);
      end
      if (clear === 1'b1) begin
        int e;
        e = (clr_q.size() > 0) ? clr_q.pop_front() : -1;
        chk("clear cycle", cyc, e);
      end else if (clr_q.size() > 0 && clr_q[0] <= cyc) begin
        void'(clr_q.pop_front());
        chk("clear expected", clear, 1'b1);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void trunc(input int last);
    while (tick_q.size() > 0 && tick_q[$] > last) void'(tick_q.pop_back());
  endfunction

  function automatic void sched_run(input int start, input int p0);
    r_start = start;
    r_p0    = p0;
    for (int t = start + CNT - p0; t <= start + 400; t += CNT) tick_q.push_back(t);
  endfunction

  task automatic do_press(input bit s, input bit c, input bit p, input int hold, input int align);
    int L, old, guard;
    guard = 0;
    if (align >= 0 && m_state == 1) begin
      while (((cyc + LAT - r_start + r_p0) % CNT) != align && guard < CNT) begin
        idle(1);
        guard++;
      end
    end
    L   = cyc + LAT;
    old = m_state;
    if (c) begin
      if (m_state == 1) trunc(L);
      clr_q.push_back(L);
      m_state = 0;
    end else if (s) begin
      case (m_state)
        0: begin m_state = 1; sched_run(L, 0); end
        1: begin trunc(L); m_held = (r_p0 + L - r_start) % CNT; m_state = 2; end
        default: begin m_state = 1; sched_run(L, m_held); end
      endcase
    end
`ifdef STEP_KEY_EN
    if (p && !c && old != 1) tick_q.push_back(L);
`endif
    ks = ~s; kc = ~c; kp = ~p;
    for (int k = 1; k <= ((hold > LAT) ? hold : LAT); k++) begin
      idle(1);
      if (k == hold) begin ks = 1'b1; kc = 1'b1; kp = 1'b1; end
      if (k == LAT - 1) chk("state before reaction edge", state, old);
      if (k == LAT) begin
        chk("state after press", state, m_state);
        chk("running after press", running, (m_state == 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int R;
    //          s  c  p  hold align gap
    tbl[0]  = '{1, 0, 0, 10,  -1,  35};  // IDLE->RUN after bounce, ticks +10/+20/+30
    tbl[1]  = '{1, 0, 0, 6,    6,  50};  // pause with 6 counts held, no ticks
    tbl[2]  = '{1, 0, 0, 6,   -1,  12};  // resume, tick 4 later
    tbl[3]  = '{1, 1, 0, 6,   -1,  30};  // start+clear together in RUN
    tbl[4]  = '{0, 1, 0, 6,   -1,  15};  // clear in IDLE
    tbl[5]  = '{1, 0, 0, 6,   -1,  12};  // RUN
    tbl[6]  = '{1, 0, 0, 6,    0,  12};  // pause on the wrap edge, tick still issued
    tbl[7]  = '{0, 0, 1, 6,   -1,  12};  // step in PAUSE
    tbl[8]  = '{1, 0, 0, 6,   -1,  12};  // resume from 0
    tbl[9]  = '{0, 0, 1, 6,   -1,  12};  // step in RUN ignored
    tbl[10] = '{1, 0, 0, 6,   -1,  12};  // PAUSE
    tbl[11] = '{0, 1, 1, 6,   -1,  12};  // clear+step: clear wins, no step tick
    tbl[12] = '{0, 0, 1, 6,   -1,  12};  // step in IDLE

    // reset
    rst = 1'b1;
    idle(3);
    chk("reset state", state, 2'd0);
    chk("reset tick", tick, 1'b0);
    chk("reset clear", clear, 1'b0);
    chk("reset running", running, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(20);
    chk("idle after reset", state, 2'd0);

    // bounce rejection: 3 low, 2 high, 3 low
    ks = 1'b0; idle(3);
    ks = 1'b1; idle(2);
    ks = 1'b0; idle(3);
    ks = 1'b1; idle(15);
    chk("bounce rejected", state, 2'd0);

    foreach (tbl[i]) begin
      do_press(tbl[i].s, tbl[i].c, tbl[i].p, tbl[i].hold, tbl[i].align);
      idle(tbl[i].gap);
    end

    // reset landing on the edge a tick is due
    do_press(1'b1, 1'b0, 1'b0, 6, -1);
    R = cyc;
    idle(9);
    rst = 1'b1;
    trunc(R + 9);
    m_state = 0;
    idle(1);
    chk("mid reset tick", tick, 1'b0);
    chk("mid reset state", state, 2'd0);
    chk("mid reset running", running, 1'b0);
    chk("mid reset clear", clear, 1'b0);
    rst = 1'b0;
    idle(25);
    chk("state after mid reset", state, 2'd0);

    chk("ticks outstanding", tick_q.size(), 0);
    chk("clears outstanding", clr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control stage directly upstream of the 0-999 seconds counter/BCD display block.
- Converts two raw active-low DE2 pushbuttons (start/stop, clear) into clean control pulses.
- Synchronises and debounces both keys, runs an IDLE/RUN/PAUSE state machine, and generates the 1 s count-enable tick.
- Downstream counter increments on `tick` and zeroes on `clear`.

Parameters:
- COUNT_1S, 50_000_000, clock cycles per tick period.
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised key must be stable before it is accepted (20 ms at 50 MHz).
- PW, 26, prescaler width; must hold COUNT_1S-1.
- DW, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock (CLOCK_50)
- rst  input  1  synchronous active-high reset
- key_start_n  input  1  raw start/stop pushbutton, active-low, asynchronous
- key_clear_n  input  1  raw clear pushbutton, active-low, asynchronous
- key_step_n  input  1  raw single-step pushbutton, active-low; used only with STEP_KEY_EN
- tick  output  1  one-cycle count-enable pulse to the counter
- clear  output  1  one-cycle pulse; counter returns to 0
- state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE (3 unused)
- running  output  1  high while state == RUN (drives LEDG)

Behaviour:
- Reset (rst sampled high at posedge clk):
  - state = IDLE; tick, clear, running = 0.
  - Prescaler and debounce counters = 0.
  - Synchroniser and debounced levels = 1 (released), so reset release never produces a press event.
- Synchroniser: each key passes through 2 flip-flops before any other use.
- Debounce, per key:
  - A counter increments each cycle the synchronised level differs from the debounced level.
  - It clears on any cycle the two are equal.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
- Press event: registered one-cycle pulse on a debounced 1->0 transition. Release produces no event. A held key produces exactly one event.
- Latency: the FSM reacts on the edge DEBOUNCE_CYCLES+3 cycles after the key is first sampled low, counting 2 sync, DEBOUNCE_CYCLES debounce and 1 event register.
- FSM transitions:
  - IDLE + start event -> RUN.
  - RUN + start event -> PAUSE.
  - PAUSE + start event -> RUN.
  - Any state + clear event -> IDLE.
- clear output: pulses high for exactly one cycle on the edge the clear event is taken, in every state, including IDLE.
- Simultaneous start and clear events in the same cycle: clear wins; state = IDLE; the start event is discarded.
- Prescaler:
  - In RUN it counts 0..COUNT_1S-1 and wraps to 0.
  - In PAUSE it holds its value; resume continues from the held value, so partial seconds are preserved.
  - In IDLE, and on the clear event, it is forced to 0.
- tick:
  - Registered: tick <= (state == RUN) && (prescaler == COUNT_1S-1).
  - Exactly one cycle high every COUNT_1S cycles in RUN.
  - First tick is COUNT_1S cycles after entering RUN from IDLE.
  - If a start or clear event leaves RUN on the same edge the prescaler wraps, that tick is still issued, because it is evaluated on the pre-edge state.
- running is registered and equals (next state == RUN), so it changes on the same edge as state.
- rst asserted mid-operation: the next edge applies reset values; a pending tick or clear is suppressed.

Optional Feature:
- Macro: STEP_KEY_EN.
- Defined:
  - key_step_n gets its own 2-FF synchroniser and debouncer.
  - A step event in IDLE or PAUSE emits one tick pulse on the event edge; state and prescaler are unchanged.
  - A step event in RUN is ignored.
  - A clear event in the same cycle suppresses the step tick.
- Not defined: key_step_n is ignored and no step logic is built.

Test Plan:
All scenarios use COUNT_1S=10, DEBOUNCE_CYCLES=4.
- Reset: hold rst 3 cycles with keys released -> state=0, tick=0, clear=0, running=0; no events for 20 cycles after release.
- Bounce rejection: start key low 3 cycles, high 2, low 3, then high -> no state change. Then hold low 10 cycles -> state 0->1 exactly 7 edges after the first low sample; one event only.
- Run ticks: enter RUN, run 35 cycles -> tick pulses at cycles 10, 20, 30 after entry, each 1 cycle wide.
- Pause/resume: start press with prescaler at 6 -> PAUSE, no ticks for 50 cycles. Press start again -> next tick 4 cycles after resume.
- Clear priority: start and clear pressed simultaneously in RUN -> state=IDLE, clear high exactly 1 cycle, no further ticks. Clear pressed in IDLE -> clear pulse, state stays 0.
- STEP_KEY_EN build: step press in PAUSE -> one tick, state stays 2. Step press in RUN -> no extra tick.
